pc_gen: RTL
===========

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning PC width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 0, meaning PC value after reset.
REQ-003 SHALL have parameter TRAP_VEC, default 32'h0000_0100, meaning PC loaded on trap or misaligned redirect.
REQ-004 SHALL have parameter INC, default 4, meaning sequential PC increment in bytes (legal: 2 or 4).
REQ-005 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-low reset (0 = reset).
REQ-007 SHALL have port en, input, 1, fetch advance enable (0 = stall).
REQ-008 SHALL have port redirect_valid, input, 1, branch/jump redirect request.
REQ-009 SHALL have port redirect_target, input, XLEN, redirect destination.
REQ-010 SHALL have port trap_valid, input, 1, trap request.
REQ-011 SHALL have port halt_req, input, 1, enter HALT.
REQ-012 SHALL have port resume, input, 1, leave HALT.
REQ-013 SHALL have port PC, output, XLEN, current fetch PC.
REQ-014 SHALL have port PCPlus, output, XLEN, PC + INC, combinational, modulo 2^XLEN.
REQ-015 SHALL have port pc_valid, output, 1, PC is a live fetch address.
REQ-016 SHALL have port misaligned, output, 1, one-cycle pulse on rejected redirect.
REQ-017 SHALL have port halted, output, 1, high while in HALT.

Function
REQ-018 SHALL implement states BOOT, RUN, HALT; reset enters BOOT.
REQ-019 BOOT SHALL last exactly one cycle, hold PC = RESET_VEC, drive pc_valid = 0, then go to RUN unconditionally.
REQ-020 RUN SHALL drive pc_valid = 1; HALT SHALL drive pc_valid = 0 and halted = 1.
REQ-021 RUN with halt_req = 1 and en = 1 SHALL go to HALT next cycle, with PC taking its normal next value.
REQ-022 HALT with resume = 1 SHALL return to RUN next cycle; PC SHALL be unchanged in HALT except by trap.
REQ-023 PC next-value priority in RUN with en = 1 SHALL be: trap > redirect_valid > pending redirect > PC + INC.
REQ-024 trap_valid SHALL load TRAP_VEC regardless of en or state (BOOT excepted), clear any pending redirect, and force RUN.
REQ-025 A redirect with en = 0 SHALL be captured into a one-entry pending register (target + valid); PC SHALL hold.
REQ-026 A later redirect while pending SHALL overwrite the pending target (newest wins).
REQ-027 The pending redirect SHALL be applied and cleared on the first subsequent RUN cycle with en = 1.
REQ-028 A redirect or pending target with target mod INC != 0 SHALL load TRAP_VEC instead and pulse misaligned for exactly the cycle after the load.
REQ-029 Sequential increment SHALL wrap modulo 2^XLEN without flag.
REQ-030 en = 0 in RUN with no trap SHALL hold PC and all state.
REQ-031 Redirect inputs during BOOT or HALT SHALL be ignored (not pended).

Reset
REQ-032 reset = 0 at a rising edge SHALL set PC = RESET_VEC, state = BOOT, pending valid = 0, misaligned = 0, halted = 0, pc_valid = 0, overriding all other inputs, including mid-redirect or mid-HALT.
REQ-033 Reset SHALL take effect only on clock edges; no asynchronous path.

Verification
REQ-034 Release reset, en = 1 -> cycle 1: PC = 0, pc_valid = 0; cycle 2: PC = 0, pc_valid = 1; then PC = 4, 8, 12.
REQ-035 At PC = 8, en = 0, redirect_valid = 1, target = 0x40, then redirect target 0x80 while still stalled, then en = 1 -> PC holds 8 during stall, next PC = 0x80, then 0x84.
REQ-036 At PC = 0x10, trap_valid = 1 and redirect_valid = 1 (target 0x200) same cycle -> PC = 0x100, pending cleared, next PC = 0x104.
REQ-037 Redirect to 0x42 with INC = 4 -> PC = 0x100, misaligned high exactly one cycle.
REQ-038 XLEN = 8, PC = 0xFC, en = 1 -> PC = 0x00; halt_req -> halted = 1, PC frozen until resume.
REQ-039 reset = 0 asserted while pending redirect held and in HALT -> next cycle PC = RESET_VEC, BOOT, pending discarded, halted = 0.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch program-counter generator: BOOT/RUN/HALT sequencing, traps, redirects with a one-entry pending slot.
// Latency: PC updates one cycle after the deciding inputs; PCPlus is combinational from PC.
// Backpressure: en=0 stalls the PC in RUN and parks at most one redirect (newest wins) until en returns.
module pc_gen #(
  parameter int XLEN      = 32,
  parameter     RESET_VEC = 0,
  parameter     TRAP_VEC  = 32'h0000_0100,
  parameter int INC       = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus,
  output logic            pc_valid,
  output logic            misaligned,
  output logic            halted
);

  // Sequencer states; BOOT is the reset state and lasts exactly one cycle.
  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  // Parameters resized once to the PC width so all arithmetic stays XLEN wide.
  localparam logic [XLEN-1:0] RST_PC     = XLEN'(RESET_VEC);
  localparam logic [XLEN-1:0] TRAP_PC    = XLEN'(TRAP_VEC);
  localparam logic [XLEN-1:0] INC_W      = XLEN'(INC);
  localparam logic [XLEN-1:0] ALIGN_MASK = INC_W - 1'b1;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_nxt;
  logic            pend_vld;
  logic            pend_vld_nxt;
  logic [XLEN-1:0] pend_tgt;
  logic [XLEN-1:0] pend_tgt_nxt;
  logic            mis_nxt;
  logic            take_tgt;
  logic [XLEN-1:0] tgt_sel;

  // Sequential increment wraps naturally at 2^XLEN; no overflow flag is kept.
  assign PCPlus   = pc + INC_W;
  assign PC       = pc;
  assign pc_valid = (state == ST_RUN);
  assign halted   = (state == ST_HALT);

  // Next-state / next-PC decision: trap > live redirect > pending redirect > increment.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    pend_vld_nxt = pend_vld;
    pend_tgt_nxt = pend_tgt;
    mis_nxt      = 1'b0;
    take_tgt     = 1'b0;
    tgt_sel      = '0;

    case (state)
      ST_BOOT: begin
        // Traps and redirects are not honoured here; the PC simply sits at the reset vector.
        pc_nxt    = RST_PC;
        state_nxt = ST_RUN;
      end

      ST_RUN: begin
        if (trap_valid) begin
          pc_nxt       = TRAP_PC;
          pend_vld_nxt = 1'b0;
          state_nxt    = ST_RUN;
        end else if (en) begin
          // Any advancing cycle consumes the pending slot, whether or not it is the winner.
          pend_vld_nxt = 1'b0;
          if (redirect_valid) begin
            take_tgt = 1'b1;
            tgt_sel  = redirect_target;
          end else if (pend_vld) begin
            take_tgt = 1'b1;
            tgt_sel  = pend_tgt;
          end else begin
            pc_nxt = PCPlus;
          end

          if (take_tgt) begin
            // A target not aligned to the fetch granule is turned into a trap entry.
            if ((tgt_sel & ALIGN_MASK) != '0) begin
              pc_nxt  = TRAP_PC;
              mis_nxt = 1'b1;
            end else begin
              pc_nxt = tgt_sel;
            end
          end

          if (halt_req) begin
            state_nxt = ST_HALT;
          end
        end else if (redirect_valid) begin
          // Stalled: park the redirect, newest request overwriting any older one.
          pend_vld_nxt = 1'b1;
          pend_tgt_nxt = redirect_target;
        end
      end

      ST_HALT: begin
        // PC is frozen in HALT; only a trap moves it, and a trap also wakes the core.
        if (trap_valid) begin
          pc_nxt       = TRAP_PC;
          pend_vld_nxt = 1'b0;
          state_nxt    = ST_RUN;
        end else if (resume) begin
          state_nxt = ST_RUN;
        end
      end

      default: begin
        state_nxt    = ST_BOOT;
        pc_nxt       = RST_PC;
        pend_vld_nxt = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset overriding every other input.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_BOOT;
      pc         <= RST_PC;
      pend_vld   <= 1'b0;
      pend_tgt   <= '0;
      misaligned <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      pend_vld   <= pend_vld_nxt;
      pend_tgt   <= pend_tgt_nxt;
      misaligned <= mis_nxt;
    end
  end

endmodule
